// File: rtl/iiitb_seq_pkg.sv
// Shared types and helpers for the sequence monitor.
//   seq_state_e : monitor FSM states
//   TO_GLOBAL / TO_STEP : timeout budget modes (TO_PER_STEP parameter values)
//   cnt_width() : width of a counter that must hold 0..n, never less than 1 bit
package iiitb_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_PASS = 3'd2,
      ST_FAIL = 3'd3,
      ST_TOUT = 3'd4
   } seq_state_e;

   localparam int TO_GLOBAL = 0;
   localparam int TO_STEP   = 1;

   // A zero-width counter is not legal, so a budget of 0 still gets one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/iiitb_seq_monitor_sync2.sv
// WIDTH-bit two-flop synchroniser with synchronous active-high reset.
// Ports:
//   clk  : clock
//   srst : synchronous reset, clears both stages to 0
//   d_i  : asynchronous input bus
//   q_o  : synchronised bus (two clock edges after d_i)
module iiitb_sync2 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_d, meta_q;
   logic [WIDTH-1:0] sync_d, sync_q;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/iiitb_seq_monitor.sv
// Arithmetic sequence monitor: watches a sampled bus for START, START+STEP, ...
// (COUNT terms, modulo 2^WIDTH) and reports pass, strict-mode failure or timeout.
// Ports:
//   wb_clk_i    : clock
//   wb_rst_i    : synchronous active-high reset
//   enable_i    : 1 = arm/run, 0 = return to idle and clear results
//   sample_i    : monitored bus, asynchronous to wb_clk_i
//   busy_o      : monitor is waiting for terms
//   pass_o      : sticky, all COUNT terms seen
//   fail_o      : sticky, strict mode saw an unexpected value change
//   timeout_o   : sticky, cycle budget exhausted
//   progress_o  : number of terms matched so far
//   bad_value_o : synchronised value that caused a failure, else 0
module iiitb_seq_monitor
   import iiitb_seq_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int START       = 1,
   parameter int STEP        = 1,
   parameter int COUNT       = 16,
   parameter int TIMEOUT     = 25000,
   parameter int TO_PER_STEP = 0,
   parameter int STRICT      = 0
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         enable_i,
   input  logic [WIDTH-1:0]             sample_i,
   output logic                         busy_o,
   output logic                         pass_o,
   output logic                         fail_o,
   output logic                         timeout_o,
   output logic [cnt_width(COUNT)-1:0]  progress_o,
   output logic [WIDTH-1:0]             bad_value_o
);

   localparam int PW = cnt_width(COUNT);
   localparam int CW = cnt_width(TIMEOUT);

   localparam logic [WIDTH-1:0] START_W  = WIDTH'(START);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [PW-1:0]    COUNT_P  = PW'(COUNT);
   localparam logic [CW-1:0]    TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic             TO_EN    = (TIMEOUT != 0);
   localparam logic             STRICT_EN = (STRICT != 0);
   localparam logic             PER_STEP = (TO_PER_STEP == TO_STEP);

   // ---------------------------------------------------------------
   // Input path: synchroniser, then a one-cycle history of s
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] s;

   iiitb_sync2 #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk  (wb_clk_i),
      .srst (wb_rst_i),
      .d_i  (sample_i),
      .q_o  (s)
   );

   seq_state_e       state_d, state_q;
   logic [WIDTH-1:0] prev_d, prev_q;
   logic [WIDTH-1:0] expected_d, expected_q;
   logic [PW-1:0]    progress_d, progress_q;
   logic [CW-1:0]    counter_d, counter_q;
   logic [WIDTH-1:0] bad_value_d, bad_value_q;
   logic             busy_d, busy_q;
   logic             pass_d, pass_q;
   logic             fail_d, fail_q;
   logic             timeout_d, timeout_q;

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      prev_d      = s;
      expected_d  = expected_q;
      progress_d  = progress_q;
      counter_d   = counter_q;
      bad_value_d = bad_value_q;

      if (!enable_i) begin
         // Abort: discard all progress and results.
         state_d     = ST_IDLE;
         expected_d  = START_W;
         progress_d  = '0;
         counter_d   = '0;
         bad_value_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_WAIT;
               expected_d  = START_W;
               progress_d  = '0;
               counter_d   = '0;
               bad_value_d = '0;
            end

            ST_WAIT: begin
               if (s == expected_q) begin
                  // A match beats a same-cycle expiry.
                  progress_d = progress_q + 1'b1;
                  expected_d = expected_q + STEP_W;
                  if (PER_STEP) begin
                     counter_d = '0;
                  end else if (TO_EN && (counter_q != TO_LAST)) begin
                     counter_d = counter_q + 1'b1;
                  end
                  // With a global budget the counter parks at its last value
                  // so the next non-matching cycle still expires.
                  if ((progress_q + 1'b1) == COUNT_P) begin
                     state_d = ST_PASS;
                  end
               end else if (STRICT_EN && (progress_q != '0) && (s != prev_q)) begin
                  // A held value (including the last match) never fails;
                  // only a change to something unexpected does.
                  state_d     = ST_FAIL;
                  bad_value_d = s;
               end else if (TO_EN && (counter_q == TO_LAST)) begin
                  state_d = ST_TOUT;
               end else if (TO_EN) begin
                  counter_d = counter_q + 1'b1;
               end
            end

            default: begin
               // Terminal states hold until enable_i drops.
            end
         endcase
      end

      busy_d    = (state_d == ST_WAIT);
      pass_d    = (state_d == ST_PASS);
      fail_d    = (state_d == ST_FAIL);
      timeout_d = (state_d == ST_TOUT);
   end

   // ---------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         prev_q      <= '0;
         expected_q  <= START_W;
         progress_q  <= '0;
         counter_q   <= '0;
         bad_value_q <= '0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         expected_q  <= expected_d;
         progress_q  <= progress_d;
         counter_q   <= counter_d;
         bad_value_q <= bad_value_d;
         busy_q      <= busy_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
      end
   end

   assign busy_o      = busy_q;
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign timeout_o   = timeout_q;
   assign progress_o  = progress_q;
   assign bad_value_o = bad_value_q;

endmodule
